// File: rtl/alu_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_arbiter_if : requester and shared-ALU signals of alu_arbiter          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface alu_arbiter_if;
    logic        req0;
    logic        req1;
    logic [3:0]  fsel0;
    logic [3:0]  fsel1;
    logic [7:0]  a0;
    logic [7:0]  b0;
    logic [7:0]  a1;
    logic [7:0]  b1;
    logic        done0;
    logic        done1;
    logic [15:0] result;
    logic [3:0]  sreg;
    logic        busy;
    logic        grant_id;
    logic [3:0]  alu_fsel;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [15:0] alu_result;
    logic [3:0]  alu_sreg;

    modport slave (
        input  req0, req1, fsel0, fsel1, a0, b0, a1, b1, alu_result, alu_sreg,
        output done0, done1, result, sreg, busy, grant_id, alu_fsel, alu_a, alu_b
    );

    modport master (
        output req0, req1, fsel0, fsel1, a0, b0, a1, b1, alu_result, alu_sreg,
        input  done0, done1, result, sreg, busy, grant_id, alu_fsel, alu_a, alu_b
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_arbiter : round-robin arbiter sharing one pipelined ALU between two   |
// |               requesters. Rev 1.0                                         |
// +--------------------------------------------------------------------------+
module alu_arbiter #(
    parameter int ALU_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    localparam logic [1:0] c_idle     = 2'd0;
    localparam logic [1:0] c_busy     = 2'd1;
    localparam logic [1:0] c_done     = 2'd2;
    localparam logic [2:0] c_last_cnt = 3'(ALU_LATENCY);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [2:0]  r_cnt;
    logic        r_ptr;
    logic        r_grant_id;
    logic [3:0]  r_alu_fsel;
    logic [7:0]  r_alu_a;
    logic [7:0]  r_alu_b;
    logic [15:0] r_result;
    logic [3:0]  r_sreg;

    logic        w_any_req;
    logic        w_winner;
    logic        w_grant;
    logic        w_last_busy;
    logic        w_busy;
    logic        w_done0;
    logic        w_done1;

    assign w_any_req   = bus.req0 | bus.req1;
    // Under contention the pointer names the winner; otherwise the lone requester wins.
    assign w_winner    = (bus.req0 & bus.req1) ? r_ptr : bus.req1;
    assign w_grant     = (r_state == c_idle) & w_any_req;
    assign w_last_busy = (r_state == c_busy) & (r_cnt == c_last_cnt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (w_any_req)   w_next_state = c_busy;
            c_busy:  if (w_last_busy) w_next_state = c_done;
            c_done:  w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    always_comb begin
        w_busy  = 1'b0;
        w_done0 = 1'b0;
        w_done1 = 1'b0;
        case (r_state)
            c_busy: w_busy = 1'b1;
            c_done: begin
                w_busy  = 1'b1;
                w_done0 = ~r_grant_id;
                w_done1 = r_grant_id;
            end
            default: w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= 3'd0;
            r_ptr      <= 1'b0;
            r_grant_id <= 1'b0;
            r_alu_fsel <= 4'd0;
            r_alu_a    <= 8'd0;
            r_alu_b    <= 8'd0;
            r_result   <= 16'd0;
            r_sreg     <= 4'd0;
        end else begin
            if (w_grant) begin
                r_cnt      <= 3'd0;
                r_grant_id <= w_winner;
                r_ptr      <= ~w_winner;
                r_alu_fsel <= w_winner ? bus.fsel1 : bus.fsel0;
                r_alu_a    <= w_winner ? bus.a1    : bus.a0;
                r_alu_b    <= w_winner ? bus.b1    : bus.b0;
            end else if (r_state == c_busy) begin
                r_cnt <= r_cnt + 3'd1;
            end
            if (w_last_busy) begin
                r_result <= bus.alu_result;
                r_sreg   <= bus.alu_sreg;
            end
        end
    end

    assign bus.done0    = w_done0;
    assign bus.done1    = w_done1;
    assign bus.busy     = w_busy;
    assign bus.grant_id = r_grant_id;
    assign bus.alu_fsel = r_alu_fsel;
    assign bus.alu_a    = r_alu_a;
    assign bus.alu_b    = r_alu_b;
    assign bus.result   = r_result;
    assign bus.sreg     = r_sreg;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_arbiter : randomized and directed bench for alu_arbiter            |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_alu_arbiter;

    localparam int L1 = 1;
    localparam int L3 = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_arbiter_if bus1 ();
    alu_arbiter_if bus3 ();

    alu_arbiter #(.ALU_LATENCY(L1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    alu_arbiter #(.ALU_LATENCY(L3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    // ALU stubs: result = {a,b}, sreg = fsel, delayed by the configured latency
    always @(posedge clk) begin
        bus1.alu_result <= {bus1.alu_a, bus1.alu_b};
        bus1.alu_sreg   <= bus1.alu_fsel;
    end

    logic [19:0] pipe3 [3];
    always @(posedge clk) begin
        pipe3[0] <= {bus3.alu_fsel, bus3.alu_a, bus3.alu_b};
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign bus3.alu_result = pipe3[2][15:0];
    assign bus3.alu_sreg   = pipe3[2][19:16];

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @edge %0d: got %h expected %h", tag, edge_n, got, exp);
        end
    endtask

    // Transaction-level reference: one operation in flight, sampled only when free
    bit          m_ptr;
    int          m_free;
    bit          m_pend;
    bit          m_pend_id;
    logic [15:0] m_pend_res;
    logic [3:0]  m_pend_sreg;
    int          m_pend_due;
    logic        m_done0, m_done1, m_busy, m_grant;
    logic [15:0] m_result;
    logic [3:0]  m_sreg;
    logic [19:0] m_alu;

    task automatic model_step();
        int e;
        bit win;
        e = edge_n + 1;
        m_done0 = 1'b0;
        m_done1 = 1'b0;
        if (!rst_n) begin
            m_ptr = 0; m_free = 0; m_pend = 0;
            m_grant = 0; m_result = 0; m_sreg = 0; m_alu = 0;
        end else begin
            if (m_free == 0 && (bus1.req0 || bus1.req1)) begin
                win = (bus1.req0 && bus1.req1) ? m_ptr : bus1.req1;
                m_ptr   = !win;
                m_grant = win;
                m_alu   = win ? {bus1.fsel1, bus1.a1, bus1.b1} : {bus1.fsel0, bus1.a0, bus1.b0};
                m_pend      = 1;
                m_pend_id   = win;
                m_pend_res  = m_alu[15:0];
                m_pend_sreg = m_alu[19:16];
                m_pend_due  = e + L1 + 1;
                m_free      = L1 + 2;
            end else if (m_free > 0) begin
                m_free--;
            end
            if (m_pend && e == m_pend_due) begin
                m_result = m_pend_res;
                m_sreg   = m_pend_sreg;
                m_done0  = !m_pend_id;
                m_done1  = m_pend_id;
                m_pend   = 0;
            end
        end
        m_busy = m_pend || m_done0 || m_done1;
    endtask

    task automatic check_outputs();
        check_eq("done0",    bus1.done0,    m_done0);
        check_eq("done1",    bus1.done1,    m_done1);
        check_eq("busy",     bus1.busy,     m_busy);
        check_eq("grant_id", bus1.grant_id, m_grant);
        check_eq("result",   bus1.result,   m_result);
        check_eq("sreg",     bus1.sreg,     m_sreg);
        check_eq("alu_ops",  {bus1.alu_fsel, bus1.alu_a, bus1.alu_b}, m_alu);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    int          done_at;
    int          busy_cnt;
    int          n_seen;
    bit          seen_id [2];
    logic [15:0] seen_res [2];
    int          gq [$];

    initial begin
        rst_n = 1'b0;
        bus1.req0 = 0; bus1.req1 = 0; bus1.fsel0 = 0; bus1.fsel1 = 0;
        bus1.a0 = 0; bus1.b0 = 0; bus1.a1 = 0; bus1.b1 = 0;
        bus3.req0 = 0; bus3.req1 = 0; bus3.fsel0 = 0; bus3.fsel1 = 0;
        bus3.a0 = 0; bus3.b0 = 0; bus3.a1 = 0; bus3.b1 = 0;

        tick();
        tick();
        check_eq("rst_result", bus1.result, 16'h0000);
        check_eq("rst_busy",   bus1.busy,   1'b0);
        rst_n = 1'b1;
        tick();

        // single request from requester 0
        bus1.req0 = 1; bus1.fsel0 = 4'd1; bus1.a0 = 8'd6; bus1.b0 = 8'd9;
        tick();
        bus1.req0 = 0;
        done_at = -1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus1.done0 && done_at < 0) done_at = i;
        end
        check_eq("single_latency", done_at, 2);
        check_eq("single_result",  bus1.result, 16'h0609);
        check_eq("single_sreg",    bus1.sreg, 4'd1);

        // simultaneous requests straight after reset
        do_reset();
        bus1.req0 = 1; bus1.fsel0 = 4'd2; bus1.a0 = 8'd3;   bus1.b0 = 8'd6;
        bus1.req1 = 1; bus1.fsel1 = 4'd3; bus1.a1 = 8'd127; bus1.b1 = 8'd125;
        n_seen = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if ((bus1.done0 || bus1.done1) && n_seen < 2) begin
                seen_id[n_seen]  = bus1.done1;
                seen_res[n_seen] = bus1.result;
                n_seen++;
            end
            if (bus1.done0) bus1.req0 = 0;
            if (bus1.done1) bus1.req1 = 0;
        end
        check_eq("simul_count", n_seen, 2);
        if (n_seen == 2) begin
            check_eq("simul_first_id",   seen_id[0],  1'b0);
            check_eq("simul_first_res",  seen_res[0], 16'h0306);
            check_eq("simul_second_id",  seen_id[1],  1'b1);
            check_eq("simul_second_res", seen_res[1], 16'h7F7D);
        end
        check_eq("simul_sreg", bus1.sreg, 4'd3);

        // continuous contention
        do_reset();
        bus1.req0 = 1; bus1.req1 = 1;
        gq.delete();
        for (int i = 0; i < 24; i++) begin
            tick();
            if (bus1.done0 || bus1.done1) gq.push_back(int'(bus1.grant_id));
        end
        bus1.req0 = 0; bus1.req1 = 0;
        check_eq("contend_grants", (gq.size() >= 4), 1'b1);
        if (gq.size() >= 4) begin
            check_eq("contend_g0", gq[0], 0);
            check_eq("contend_g1", gq[1], 1);
            check_eq("contend_g2", gq[2], 0);
            check_eq("contend_g3", gq[3], 1);
        end
        for (int i = 0; i < 4; i++) tick();

        // operand change while busy
        bus1.req0 = 1; bus1.fsel0 = 4'd7; bus1.a0 = 8'h21; bus1.b0 = 8'h43;
        tick();
        bus1.req0 = 0; bus1.a0 = 8'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("hold_alu_a", bus1.alu_a, 8'h21);
        end
        check_eq("hold_result", bus1.result, 16'h2143);
        tick();

        // reset while busy
        bus1.req0 = 1; bus1.a0 = 8'd1; bus1.b0 = 8'd2;
        tick();
        bus1.req0 = 0;
        tick();
        do_reset();
        check_eq("abort_result", bus1.result, 16'h0000);
        check_eq("abort_alu_a",  bus1.alu_a,  8'h00);
        busy_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus1.done0 || bus1.done1) busy_cnt++;
        end
        check_eq("abort_no_done", busy_cnt, 0);
        bus1.req1 = 1; bus1.fsel1 = 4'd0; bus1.a1 = 8'd13; bus1.b1 = 8'd85;
        tick();
        bus1.req1 = 0;
        for (int i = 0; i < 4; i++) tick();
        check_eq("abort_next_res", bus1.result, 16'h0D55);

        // randomized traffic with occasional resets and dropped requests
        for (int i = 0; i < 400; i++) begin
            if (bus1.done0)     bus1.req0 = 0;
            else if (bus1.req0) bus1.req0 = ($urandom_range(0, 19) != 0);
            else                bus1.req0 = ($urandom_range(0, 2) == 0);
            if (bus1.done1)     bus1.req1 = 0;
            else if (bus1.req1) bus1.req1 = ($urandom_range(0, 19) != 0);
            else                bus1.req1 = ($urandom_range(0, 2) == 0);
            bus1.fsel0 = 4'($urandom); bus1.a0 = 8'($urandom); bus1.b0 = 8'($urandom);
            bus1.fsel1 = 4'($urandom); bus1.a1 = 8'($urandom); bus1.b1 = 8'($urandom);
            rst_n = ($urandom_range(0, 149) != 0);
            tick();
        end
        bus1.req0 = 0; bus1.req1 = 0; rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // latency sweep on the ALU_LATENCY=3 instance
        bus3.req0 = 1; bus3.fsel0 = 4'hA; bus3.a0 = 8'h12; bus3.b0 = 8'h34;
        tick();
        bus3.req0 = 0;
        busy_cnt = bus3.busy ? 1 : 0;
        done_at  = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus3.busy) busy_cnt++;
            if (bus3.done0 && done_at < 0) done_at = i;
        end
        check_eq("lat3_done_edge", done_at, 4);
        check_eq("lat3_busy_cnt",  busy_cnt, 5);
        check_eq("lat3_result",    bus3.result, 16'h1234);
        check_eq("lat3_sreg",      bus3.sreg, 4'hA);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
